// File: rtl/led_phase_scheduler_if.sv
// Sample-pair handshake between led_phase_scheduler (master) and the Controller (slave).
// One IR/RED pair per frame, held under frame_valid until accepted with frame_ready.
interface led_phase_scheduler_if;
    logic       frame_valid;
    logic       frame_ready;
    logic [7:0] IR_ADC_Value;
    logic [7:0] RED_ADC_Value;

    modport master (
        output frame_valid,
        output IR_ADC_Value,
        output RED_ADC_Value,
        input  frame_ready
    );

    modport slave (
        input  frame_valid,
        input  IR_ADC_Value,
        input  RED_ADC_Value,
        output frame_ready
    );
endinterface

// File: rtl/led_phase_scheduler.sv
// IR/RED LED time-multiplexer and ADC sample sequencer for the pulse-oximeter front end.
// Define AMBIENT_CANCEL_EN to add a dark phase whose sample is subtracted (saturating) from both channels.
module led_phase_scheduler #(
    parameter int SETTLE_CYCLES = 4,
    parameter int FRAME_CYCLES  = 20
) (
    input  logic                         CLK,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [7:0]                   ADC,
    led_phase_scheduler_if.master        frame_if,
    output logic                         LED_IR,
    output logic                         LED_RED,
    output logic                         adc_sample,
    output logic                         overrun,
    output logic                         busy
);

    localparam int CNT_W = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;

    // Frame-counter values on which each timed state hands over to the next one.
    localparam logic [CNT_W-1:0] IR_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RED_LAST = CNT_W'(2 * SETTLE_CYCLES);
`ifdef AMBIENT_CANCEL_EN
    localparam logic [CNT_W-1:0] DARK_LAST = CNT_W'(3 * SETTLE_CYCLES + 1);
`endif
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(FRAME_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        IR_SETTLE,
        IR_SAMPLE,
        RED_SETTLE,
        RED_SAMPLE,
`ifdef AMBIENT_CANCEL_EN
        DARK_SETTLE,
        DARK_SAMPLE,
`endif
        GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       ir_raw_q, ir_raw_d;
    logic [7:0]       red_raw_q, red_raw_d;
    logic [7:0]       ir_out_q, ir_out_d;
    logic [7:0]       red_out_q, red_out_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             publish;
    logic [7:0]       ir_pub;
    logic [7:0]       red_pub;

`ifdef AMBIENT_CANCEL_EN
    logic [7:0] dark_val;

    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : 8'h00;
    endfunction
`endif

    // Sequencer: one shared frame counter times every settle phase and the gap.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        ir_raw_d  = ir_raw_q;
        red_raw_d = red_raw_q;
        publish   = 1'b0;
`ifdef AMBIENT_CANCEL_EN
        dark_val  = 8'h00;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) state_d = IR_SETTLE;
            end
            IR_SETTLE: begin
                if (cnt_q == IR_LAST) state_d = IR_SAMPLE;
            end
            IR_SAMPLE: begin
                ir_raw_d = ADC;
                state_d  = RED_SETTLE;
            end
            RED_SETTLE: begin
                if (cnt_q == RED_LAST) state_d = RED_SAMPLE;
            end
            RED_SAMPLE: begin
                red_raw_d = ADC;
`ifdef AMBIENT_CANCEL_EN
                state_d   = DARK_SETTLE;
`else
                state_d   = GAP;
                publish   = 1'b1;
`endif
            end
`ifdef AMBIENT_CANCEL_EN
            DARK_SETTLE: begin
                if (cnt_q == DARK_LAST) state_d = DARK_SAMPLE;
            end
            DARK_SAMPLE: begin
                dark_val = ADC;
                state_d  = GAP;
                publish  = 1'b1;
            end
`endif
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = enable ? IR_SETTLE : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The published pair uses the values captured on this same edge.
`ifdef AMBIENT_CANCEL_EN
    assign ir_pub  = sat_sub(ir_raw_d, dark_val);
    assign red_pub = sat_sub(red_raw_d, dark_val);
`else
    assign ir_pub  = ir_raw_d;
    assign red_pub = red_raw_d;
`endif

    // Output handshake: a publish always wins over a same-cycle accept.
    always_comb begin
        valid_d   = valid_q;
        overrun_d = overrun_q;
        ir_out_d  = ir_out_q;
        red_out_d = red_out_q;
        if (publish) begin
            valid_d   = 1'b1;
            ir_out_d  = ir_pub;
            red_out_d = red_pub;
            if (valid_q && !frame_if.frame_ready) overrun_d = 1'b1;
        end else if (valid_q && frame_if.frame_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ir_raw_q  <= 8'h00;
            red_raw_q <= 8'h00;
            ir_out_q  <= 8'h00;
            red_out_q <= 8'h00;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ir_raw_q  <= ir_raw_d;
            red_raw_q <= red_raw_d;
            ir_out_q  <= ir_out_d;
            red_out_q <= red_out_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    // LED and sample strobes decode straight from the state, so they can never overlap.
    always_comb begin
        LED_IR     = (state_q == IR_SETTLE) || (state_q == IR_SAMPLE);
        LED_RED    = (state_q == RED_SETTLE) || (state_q == RED_SAMPLE);
        adc_sample = (state_q == IR_SAMPLE) || (state_q == RED_SAMPLE);
`ifdef AMBIENT_CANCEL_EN
        adc_sample = adc_sample || (state_q == DARK_SAMPLE);
`endif
        busy       = (state_q != IDLE);
    end

    assign frame_if.frame_valid   = valid_q;
    assign frame_if.IR_ADC_Value  = ir_out_q;
    assign frame_if.RED_ADC_Value = red_out_q;
    assign overrun                = overrun_q;

endmodule

// File: tb/tb_led_phase_scheduler.sv
// Scoreboard bench for led_phase_scheduler: stimulus queues expected publishes, a monitor checks them.
// Honours AMBIENT_CANCEL_EN the same way the design does.
module tb_led_phase_scheduler;

    localparam int S = 4;
    localparam int F = 20;
`ifdef AMBIENT_CANCEL_EN
    localparam bit AMB = 1'b1;
    localparam int PUB = 3 * S + 3;
`else
    localparam bit AMB = 1'b0;
    localparam int PUB = 2 * S + 2;
`endif

    logic       CLK = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] ADC;
    logic       LED_IR, LED_RED, adc_sample, overrun, busy;

    led_phase_scheduler_if fif ();

    led_phase_scheduler #(
        .SETTLE_CYCLES(S),
        .FRAME_CYCLES (F)
    ) dut (
        .CLK       (CLK),
        .rst       (rst),
        .enable    (enable),
        .ADC       (ADC),
        .frame_if  (fif),
        .LED_IR    (LED_IR),
        .LED_RED   (LED_RED),
        .adc_sample(adc_sample),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] ir;
        logic [7:0] red;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   cyc        = 0;
    bit   sb_en      = 1'b1;
    logic prev_valid = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] expv(input logic [7:0] raw, input logic [7:0] dark);
`ifdef AMBIENT_CANCEL_EN
        return (raw > dark) ? 8'(raw - dark) : 8'h00;
`else
        return raw;
`endif
    endfunction

    // Monitor: every rising frame_valid must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (sb_en && fif.frame_valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_publish", 32'(sb_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_ir_value", 32'(fif.IR_ADC_Value), 32'(e.ir));
                check("sb_red_value", 32'(fif.RED_ADC_Value), 32'(e.red));
                check("sb_pub_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        prev_valid = fif.frame_valid;
    end

    // Drives ncyc cycles of one frame starting at its cycle 0 and checks the strobes each cycle.
    task automatic run_frame(input logic [7:0] ir, input logic [7:0] red, input logic [7:0] dark,
                             input bit push, input int ncyc, input int drop_at,
                             input int ready_at, input bit ready_hold);
        exp_t       e;
        logic [3:0] ev;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge CLK);
            #1;
            if (k == 0 && push) begin
                e.ir  = expv(ir, dark);
                e.red = expv(red, dark);
                e.cyc = cyc + PUB;
                sb_q.push_back(e);
            end
            ADC = (k <= S) ? ir : (k <= 2 * S + 1) ? red : dark;
            if (k == drop_at) enable = 1'b0;
            fif.frame_ready = ready_hold || (k == ready_at);
            @(negedge CLK);
            ev[3] = (k <= S);
            ev[2] = (k >= S + 1) && (k <= 2 * S + 1);
            ev[1] = (k == S) || (k == 2 * S + 1) || (AMB && (k == 3 * S + 2));
            ev[0] = 1'b1;
            check($sformatf("frame_k%0d_strobes", k), 32'({LED_IR, LED_RED, adc_sample, busy}), 32'(ev));
        end
    endtask

    initial begin
        int viol;
        int w;
        rst             = 1'b1;
        enable          = 1'b0;
        ADC             = 8'h00;
        fif.frame_ready = 1'b0;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_outputs", 32'({LED_IR, LED_RED, adc_sample, fif.frame_valid, overrun, busy}), 32'd0);
        check("reset_ir_value", 32'(fif.IR_ADC_Value), 32'h00);
        check("reset_red_value", 32'(fif.RED_ADC_Value), 32'h00);

        @(posedge CLK); #1 rst = 1'b0;
        @(posedge CLK); #1 enable = 1'b1;
        @(negedge CLK);
        check("idle_not_busy", 32'(busy), 32'd0);

        // Two frames without accept; the second drops enable at cycle 3 and returns to IDLE.
        run_frame(8'd200, 8'd150, 8'd30, 1'b1, F, -1, -1, 1'b0);
        run_frame(8'd220, 8'd150, 8'd180, 1'b0, F, 3, -1, 1'b0);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("stop_idle", 32'({LED_IR, LED_RED, busy}), 32'd0);
        check("overrun_valid_held", 32'(fif.frame_valid), 32'd1);
        check("overrun_flag", 32'(overrun), 32'd1);
        check("overrun_ir_new", 32'(fif.IR_ADC_Value), 32'(expv(8'd220, 8'd180)));
        check("overrun_red_new", 32'(fif.RED_ADC_Value), 32'(expv(8'd150, 8'd180)));

        @(posedge CLK); #1 fif.frame_ready = 1'b1;
        @(posedge CLK); #1 fif.frame_ready = 1'b0;
        @(negedge CLK);
        check("accept_clears_valid", 32'(fif.frame_valid), 32'd0);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Reset during RED settle discards the partial frame.
        @(posedge CLK); #1 enable = 1'b1;
        run_frame(8'd60, 8'd90, 8'd20, 1'b0, 7, -1, -1, 1'b0);
        @(posedge CLK); #1 rst = 1'b1;
        @(negedge CLK);
        check("rst_cycle7_red_on", 32'(LED_RED), 32'd1);
        @(posedge CLK); #1 rst = 1'b0;
        @(negedge CLK);
        check("midrst_outputs", 32'({LED_IR, LED_RED, adc_sample, fif.frame_valid, overrun, busy}), 32'd0);
        check("midrst_values", 32'({fif.IR_ADC_Value, fif.RED_ADC_Value}), 32'd0);

        // Restart, then a second frame whose publish meets a same-cycle accept.
        run_frame(8'd60, 8'd90, 8'd20, 1'b1, F, -1, -1, 1'b0);
        run_frame(8'd70, 8'd80, 8'd10, 1'b0, F, 3, PUB - 1, 1'b0);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("coincide_valid", 32'(fif.frame_valid), 32'd1);
        check("coincide_no_overrun", 32'(overrun), 32'd0);
        check("coincide_ir", 32'(fif.IR_ADC_Value), 32'(expv(8'd70, 8'd10)));
        check("coincide_red", 32'(fif.RED_ADC_Value), 32'(expv(8'd80, 8'd10)));
        check("coincide_idle", 32'(busy), 32'd0);

        // Consumer always ready: valid pulses for one cycle.
        @(posedge CLK); #1 enable = 1'b1;
        run_frame(8'd5, 8'd255, 8'd0, 1'b1, F, 3, -1, 1'b1);
        @(posedge CLK); #1 fif.frame_ready = 1'b0;
        @(negedge CLK);
        check("ready_valid_cleared", 32'(fif.frame_valid), 32'd0);
        check("ready_no_overrun", 32'(overrun), 32'd0);

        // Random enable/ready traffic: LEDs must stay mutually exclusive.
        sb_en = 1'b0;
        viol  = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge CLK);
            #1;
            enable          = 1'($urandom_range(0, 1));
            fif.frame_ready = 1'($urandom_range(0, 1));
            ADC             = 8'($urandom);
            @(negedge CLK);
            if (LED_IR && LED_RED) viol++;
        end
        check("led_exclusive", 32'(viol), 32'd0);

        @(posedge CLK); #1 enable = 1'b0;
        w = 0;
        while (busy && w < 2 * F) begin
            @(negedge CLK);
            w++;
        end
        check("drain_to_idle", 32'(busy), 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/led_phase_scheduler.md
# led_phase_scheduler

Time-multiplexes the IR and RED LEDs of the pulse-oximeter front end and sequences ADC sampling for each phase. It sits between the shared 8-bit ADC input and the Controller's processing logic. Each frame produces one IR/RED sample pair, delivered over a valid/ready handshake. Optionally, it also takes a dark (ambient) sample and subtracts it from both channels.

## Interface
- SETTLE_CYCLES, 4: cycles a phase's LED is on before its sample cycle; legal range ≥1.
- FRAME_CYCLES, 20: frame period in cycles; must be ≥ 3*(SETTLE_CYCLES+1)+1.
- CLK  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  run request; frames repeat while high.
- ADC  input  8  ADC conversion result; sampled in SAMPLE states.
- frame_ready  input  1  consumer accepts the current sample pair.
- LED_IR  output  1  IR LED drive.
- LED_RED  output  1  RED LED drive.
- adc_sample  output  1  high during every SAMPLE-state cycle.
- IR_ADC_Value  output  8  IR result of the last completed frame.
- RED_ADC_Value  output  8  RED result of the last completed frame.
- frame_valid  output  1  sample pair available.
- overrun  output  1  sticky flag: a frame completed while frame_valid was still pending.
- busy  output  1  high in every state except IDLE.

## Operation
- States: IDLE, IR_SETTLE, IR_SAMPLE, RED_SETTLE, RED_SAMPLE, DARK_SETTLE*, DARK_SAMPLE*, GAP. States marked * exist only under the macro.
- IDLE → IR_SETTLE when enable=1.
- Each X_SETTLE state lasts SETTLE_CYCLES cycles, then moves to X_SAMPLE.
- Each X_SAMPLE state lasts 1 cycle and registers ADC into a raw register.
- Transitions: IR_SAMPLE → RED_SETTLE; RED_SAMPLE → DARK_SETTLE (macro) or GAP; DARK_SAMPLE → GAP.
- GAP lasts until the frame counter reaches FRAME_CYCLES-1. It then goes to IR_SETTLE if enable=1, else IDLE.
- enable is sampled only in IDLE and on the last GAP cycle. A started frame always completes.
- LED_IR=1 only in IR_SETTLE/IR_SAMPLE; LED_RED=1 only in RED_SETTLE/RED_SAMPLE. The two LEDs are never high together. Both are 0 in DARK states, GAP and IDLE.
- Frame counter: 0 on the first IR_SETTLE cycle, increments every cycle, sized to hold FRAME_CYCLES-1.
- Publishing: the cycle after the final sample state, the IR and RED results are written together and frame_valid is set to 1.
- Handshake: frame_valid holds until sampled high with frame_ready, then clears on the next cycle.
- If a publish coincides with a pending frame_valid (including a same-cycle accept):
  - the new data overwrites the old;
  - frame_valid stays 1;
  - overrun is set to 1 only if the old frame was not accepted that cycle.
- overrun clears only on rst.

## Timing
- Reset values: state IDLE, counter 0; LED_IR, LED_RED, adc_sample, frame_valid, overrun, busy all 0; IR_ADC_Value and RED_ADC_Value are 8'h00.
- With S=SETTLE_CYCLES and frame cycle 0 = first IR_SETTLE cycle:
  - LED_IR high in cycles 0..S; IR sampled at cycle S.
  - LED_RED high in cycles S+1..2S+1; RED sampled at cycle 2S+1.
  - Dark sampled at cycle 3S+2 (macro only).
- frame_valid rises at cycle 2S+2 without the macro, 3S+3 with it.
- The next frame's cycle 0 is frame cycle FRAME_CYCLES.
- From enable rising in IDLE to cycle 0: 1 cycle.
- rst mid-frame: on the next edge, all outputs return to their reset values, the partial frame is discarded and no publish occurs.

## Configuration
- AMBIENT_CANCEL_EN defined:
  - DARK_SETTLE/DARK_SAMPLE are included.
  - Published values are IR_raw−dark and RED_raw−dark, each saturated at 0 (unsigned 8-bit, no wrap).
- AMBIENT_CANCEL_EN undefined:
  - No dark phase.
  - Raw values are published unchanged.
  - The frame-length constraint relaxes to FRAME_CYCLES ≥ 2*(SETTLE_CYCLES+1)+1.

## Test plan
- Basic frame, no macro, S=4, F=20, ADC=200 during IR sample and 150 during RED sample, frame_ready=0:
  - LED_IR high cycles 0–4, LED_RED high cycles 5–9;
  - adc_sample high at cycles 4 and 9;
  - frame_valid rises at cycle 10 with IR=200, RED=150;
  - next frame's cycle 0 is cycle 20.
- Ambient cancel (macro), IR=200, RED=150, dark=30 → IR=170, RED=120, frame_valid at cycle 15. With dark=180, RED=150 → RED=0 (saturated).
- Handshake: frame_ready held 0 for two frames → overrun=1, second frame's data is present, frame_valid=1. Then frame_ready=1 for 1 cycle → frame_valid=0 next cycle, overrun stays 1.
- Stop: enable dropped at cycle 3 → frame completes and publishes, returns to IDLE at cycle 20, busy=0.
- Reset mid-frame: rst asserted at cycle 7 (LED_RED=1) → next cycle all outputs 0 and state IDLE; no frame_valid; enable=1 then restarts with cycle 0 one cycle after rst drops.
- LED exclusivity: over 1000 random-enable cycles, LED_IR & LED_RED is never 1.
